// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler: load-use bubbles, mul/div hold in EX, taken-branch flushes.
// Latency: outputs are combinational from state + inputs. Backpressure: the mul/div busy window freezes the front end until done or timeout.
module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic             ex_branch_taken,
    input  logic             ex_md_valid,
    input  logic             md_done,
    input  logic             cnt_clear,
    output logic             PCEnable,
    output logic             IF_ID_writeEnable,
    output logic             ID_EX_writeEnable,
    output logic             ControlEnable,
    output logic             EX_MEM_ControlEn,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             md_start,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int MDC_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [MDC_W-1:0] MD_LIMIT = MDC_W'(MD_TIMEOUT);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t           state_q, state_d;
    logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic load_use;
    logic pc_en, ifid_we, idex_we, ctrl_en, exmem_en;
    logic ifid_fl, idex_fl, start_p, timeout_p;
    logic flush_inc;

    assign load_use = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                      ((ID_EX_RegisterRd == IF_ID_RegisterRs1) ||
                       (ID_EX_RegisterRd == IF_ID_RegisterRs2));

    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        pc_en     = 1'b1;
        ifid_we   = 1'b1;
        idex_we   = 1'b1;
        ctrl_en   = 1'b1;
        exmem_en  = 1'b1;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        start_p   = 1'b0;
        timeout_p = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_fl   = 1'b1;
                    idex_fl   = 1'b1;
                    flush_inc = 1'b1;
                end else if (ex_md_valid) begin
                    start_p = 1'b1;
                    // A unit that answers in the same cycle needs no hold at all.
                    if (!md_done) begin
                        pc_en    = 1'b0;
                        ifid_we  = 1'b0;
                        idex_we  = 1'b0;
                        exmem_en = 1'b0;
                        md_cnt_d = MDC_W'(1);
                        state_d  = MD_BUSY;
                    end
                end else if (load_use) begin
                    pc_en   = 1'b0;
                    ifid_we = 1'b0;
                    ctrl_en = 1'b0;
                end
            end
            MD_BUSY: begin
                if (md_done) begin
                    md_cnt_d = '0;
                    state_d  = RUN;
                end else if (md_cnt_q == MD_LIMIT) begin
                    timeout_p = 1'b1;
                    md_cnt_d  = '0;
                    state_d   = RUN;
                end else begin
                    pc_en    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_we  = 1'b0;
                    exmem_en = 1'b0;
                    md_cnt_d = md_cnt_q + MDC_W'(1);
                end
            end
            default: begin
                md_cnt_d = '0;
                state_d  = RUN;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (cnt_clear) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!pc_en && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
            if (flush_inc && !(&flush_q)) flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    // Held in reset, every control output is forced low without waiting for a clock.
    assign PCEnable          = rst_n & pc_en;
    assign IF_ID_writeEnable = rst_n & ifid_we;
    assign ID_EX_writeEnable = rst_n & idex_we;
    assign ControlEnable     = rst_n & ctrl_en;
    assign EX_MEM_ControlEn  = rst_n & exmem_en;
    assign IF_ID_flush       = rst_n & ifid_fl;
    assign ID_EX_flush       = rst_n & idex_fl;
    assign md_start          = rst_n & start_p;
    assign md_timeout        = rst_n & timeout_p;
    assign stall_count       = stall_q;
    assign flush_count       = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vectors checked every cycle against a behavioural model,
// plus hand-computed literal expectations at the interesting points.
module tb_pipeline_ctrl;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic memread, br, mdv, done, clr;
    logic [4:0] rd, rs1, rs2;
    logic pc_en, ifid_we, idex_we, ctrl_en, exmem_en, ifid_fl, idex_fl, mstart, mtimeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    bit m_busy;
    int m_cyc, m_stall, m_flush;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_MemRead(memread), .ID_EX_RegisterRd(rd),
        .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
        .ex_branch_taken(br), .ex_md_valid(mdv), .md_done(done), .cnt_clear(clr),
        .PCEnable(pc_en), .IF_ID_writeEnable(ifid_we), .ID_EX_writeEnable(idex_we),
        .ControlEnable(ctrl_en), .EX_MEM_ControlEn(exmem_en),
        .IF_ID_flush(ifid_fl), .ID_EX_flush(idex_fl),
        .md_start(mstart), .md_timeout(mtimeout),
        .stall_count(stall_cnt), .flush_count(flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit order: PC, IF_ID_we, ID_EX_we, Ctrl, EX_MEM, IF_ID_flush, ID_EX_flush, md_start, md_timeout
    function automatic logic [8:0] model_out();
        logic [8:0] o;
        bit lu;
        if (!rst_n) return 9'b0;
        o  = 9'b11111_0000;
        lu = memread && (rd != 0) && (rd == rs1 || rd == rs2);
        if (!m_busy) begin
            if (br) o[3:2] = 2'b11;
            else if (mdv) begin
                o[1] = 1'b1;
                if (!done) begin o[8] = 0; o[7] = 0; o[6] = 0; o[4] = 0; end
            end else if (lu) begin o[8] = 0; o[7] = 0; o[5] = 0; end
        end else if (!done) begin
            if (m_cyc == TO) o[0] = 1'b1;
            else begin o[8] = 0; o[7] = 0; o[6] = 0; o[4] = 0; end
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [8:0] e;
        if (!rst_n) begin
            m_busy <= 0; m_cyc <= 0; m_stall <= 0; m_flush <= 0;
        end else begin
            e = model_out();
            if (clr) begin
                m_stall <= 0; m_flush <= 0;
            end else begin
                if (!e[8]) m_stall <= (m_stall + 1 > SAT) ? SAT : m_stall + 1;
                if (!m_busy && br) m_flush <= (m_flush + 1 > SAT) ? SAT : m_flush + 1;
            end
            if (!m_busy) begin
                if (!br && mdv && !done) begin m_busy <= 1; m_cyc <= 1; end
            end else if (done || m_cyc == TO) begin
                m_busy <= 0; m_cyc <= 0;
            end else m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        chk("outputs_vs_model",
            {23'b0, pc_en, ifid_we, idex_we, ctrl_en, exmem_en, ifid_fl, idex_fl, mstart, mtimeout},
            {23'b0, model_out()});
        chk("stall_count_vs_model", 32'(stall_cnt), 32'(m_stall));
        chk("flush_count_vs_model", 32'(flush_cnt), 32'(m_flush));
    end

    task automatic idle();
        memread = 0; rd = 0; rs1 = 0; rs2 = 0; br = 0; mdv = 0; done = 0; clr = 0;
    endtask
    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask
    task automatic clear_cnts();
        clr = 1; step(); clr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #1;
        chk("reset_pc", 32'(pc_en), 0);
        chk("reset_exmem", 32'(exmem_en), 0);
        step(); step();
        rst_n = 1;
        mid(); chk("run_idle_pc", 32'(pc_en), 1);
        step();

        // load-use on rs1, then the rd==0 case, then a match on rs2
        memread = 1; rd = 5; rs1 = 5; rs2 = 9;
        mid();
        chk("lu_pc", 32'(pc_en), 0);
        chk("lu_ifid_we", 32'(ifid_we), 0);
        chk("lu_ctrl", 32'(ctrl_en), 0);
        chk("lu_idex_we", 32'(idex_we), 1);
        step();
        rd = 0; rs1 = 0; rs2 = 0;
        mid(); chk("rd0_no_stall", 32'(pc_en), 1);
        step();
        rd = 7; rs1 = 1; rs2 = 7;
        mid();
        chk("lu_stall_count", 32'(stall_cnt), 1);
        chk("lu_rs2_pc", 32'(pc_en), 0);
        step(); idle();
        mid(); chk("lu_rs2_stall_count", 32'(stall_cnt), 2);

        // branch beats a simultaneous load-use
        clear_cnts();
        memread = 1; rd = 5; rs1 = 5; br = 1;
        mid();
        chk("br_ifid_flush", 32'(ifid_fl), 1);
        chk("br_idex_flush", 32'(idex_fl), 1);
        chk("br_pc", 32'(pc_en), 1);
        step(); idle();
        mid();
        chk("br_stall_count", 32'(stall_cnt), 0);
        chk("br_flush_count", 32'(flush_cnt), 1);

        // mul/div finishing on the fourth busy cycle
        clear_cnts();
        mdv = 1;
        mid();
        chk("md_start", 32'(mstart), 1);
        chk("md_c0_pc", 32'(pc_en), 0);
        chk("md_c0_idex", 32'(idex_we), 0);
        chk("md_c0_exmem", 32'(exmem_en), 0);
        step();
        for (int i = 1; i <= 3; i++) begin
            mid();
            chk("md_busy_pc", 32'(pc_en), 0);
            chk("md_busy_start", 32'(mstart), 0);
            step();
        end
        mdv = 0; done = 1;
        mid();
        chk("md_done_pc", 32'(pc_en), 1);
        chk("md_done_exmem", 32'(exmem_en), 1);
        chk("md_done_idex", 32'(idex_we), 1);
        step(); idle();
        mid(); chk("md_stall_count", 32'(stall_cnt), 4);

        // timeout without md_done
        clear_cnts();
        mdv = 1; step(); mdv = 0;
        repeat (7) step();
        mid();
        chk("to_pulse", 32'(mtimeout), 1);
        chk("to_pc", 32'(pc_en), 1);
        step();
        mid();
        chk("to_after_pulse", 32'(mtimeout), 0);
        chk("to_stall_count", 32'(stall_cnt), 8);

        // md_done on the timeout cycle suppresses the pulse
        mdv = 1; step(); mdv = 0;
        repeat (7) step();
        done = 1;
        mid();
        chk("to_done_no_pulse", 32'(mtimeout), 0);
        chk("to_done_pc", 32'(pc_en), 1);
        step(); idle();

        // zero-wait op
        mdv = 1; done = 1;
        mid();
        chk("zw_start", 32'(mstart), 1);
        chk("zw_pc", 32'(pc_en), 1);
        step(); idle();
        mid(); chk("zw_stays_run", 32'(pc_en), 1);

        // saturation then clear
        clear_cnts();
        memread = 1; rd = 5; rs1 = 5;
        repeat (20) step();
        mid(); chk("stall_saturated", 32'(stall_cnt), SAT);
        clr = 1; step(); clr = 0;
        mid(); chk("stall_cleared", 32'(stall_cnt), 0);
        idle(); br = 1;
        repeat (20) step();
        mid(); chk("flush_saturated", 32'(flush_cnt), SAT);
        idle(); clear_cnts();

        // reset in the middle of a mul/div hold
        mdv = 1; step(); step();
        #3 rst_n = 0;
        #1;
        chk("arst_pc", 32'(pc_en), 0);
        chk("arst_ifid_we", 32'(ifid_we), 0);
        chk("arst_idex_we", 32'(idex_we), 0);
        chk("arst_ctrl", 32'(ctrl_en), 0);
        chk("arst_exmem", 32'(exmem_en), 0);
        chk("arst_flush", 32'({ifid_fl, idex_fl}), 0);
        chk("arst_pulses", 32'({mstart, mtimeout}), 0);
        chk("arst_stall_count", 32'(stall_cnt), 0);
        step(); idle();
        rst_n = 1;
        mid();
        chk("post_rst_pc", 32'(pc_en), 1);
        step();
        mdv = 1;
        mid(); chk("post_rst_run_start", 32'(mstart), 1);
        step(); mdv = 0; done = 1;
        step(); idle();
        step();
        mid();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
